// File: rtl/ctrl_temporizador_if.sv
// ctrl_temporizador_if: control/status bundle of the countdown timer controller
//   tiempo_def     seconds requested by the time-setting block
//   habil          enable switch level
//   pulso_inicio   start/resume pulse
//   pulso_pausa    pause pulse
//   pulso_cancelar cancel pulse
//   tiempo_rest    seconds remaining
//   estado         IDLE=0 RUN=1 PAUSE=2 DONE=3
//   fin            high while in DONE
//   alarma         one-cycle pulse on RUN->DONE
//   parpadeo       blink output, toggles each second in DONE
interface ctrl_temporizador_if;
  logic [4:0] tiempo_def;
  logic       habil;
  logic       pulso_inicio;
  logic       pulso_pausa;
  logic       pulso_cancelar;
  logic [4:0] tiempo_rest;
  logic [1:0] estado;
  logic       fin;
  logic       alarma;
  logic       parpadeo;
  modport master (
    output tiempo_def, habil, pulso_inicio, pulso_pausa, pulso_cancelar,
    input  tiempo_rest, estado, fin, alarma, parpadeo
  );
  modport slave (
    input  tiempo_def, habil, pulso_inicio, pulso_pausa, pulso_cancelar,
    output tiempo_rest, estado, fin, alarma, parpadeo
  );
endinterface

// File: rtl/ctrl_temporizador.sv
// ctrl_temporizador: countdown timer controller with pause, cancel and timed DONE blink
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    ctrl_temporizador_if.slave: setting/enable/pulses in, remaining time and status out
module ctrl_temporizador #(
  parameter int SEG_DIV = 100000000,
  parameter int MAX_T   = 20,
  parameter int DONE_S  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ctrl_temporizador_if.slave   bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam int CW = (SEG_DIV > 1) ? $clog2(SEG_DIV) : 1;
  localparam int DW = $clog2(DONE_S + 1);
  localparam logic [CW-1:0] CMAX = CW'(SEG_DIV - 1);
  localparam logic [DW-1:0] DMAX = DW'(DONE_S - 1);
  localparam logic [4:0]    TMAX = 5'(MAX_T);
  logic [1:0]    st;
  logic [4:0]    tr;
  logic          al, bl;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dcnt;
  logic [4:0]    load, idle_tr;
  logic          tick, abort, go;
  always_comb begin
    load    = (bus.tiempo_def > TMAX) ? TMAX : bus.tiempo_def;
    idle_tr = bus.habil ? load : 5'd0;
    tick    = (st == RUN || st == DONE) && cnt == CMAX;
    abort   = bus.pulso_cancelar || !bus.habil;
    go      = bus.pulso_inicio && bus.habil && load != 5'd0;
  end
  // cnt is held in PAUSE so a resume continues the interrupted second; it sits at
  // zero in IDLE, and wraps to zero on the tick that enters DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st   <= IDLE;
      tr   <= '0;
      al   <= 1'b0;
      bl   <= 1'b0;
      cnt  <= '0;
      dcnt <= '0;
    end else begin
      al   <= 1'b0;
      cnt  <= (st == RUN || st == DONE) ? (tick ? '0 : cnt + CW'(1)) : (st == PAUSE ? cnt : '0);
      dcnt <= (st == DONE) ? (tick ? dcnt + DW'(1) : dcnt) : '0;
      case (st)
        IDLE: begin
          tr <= idle_tr;
          if (go) st <= RUN;
        end
        RUN:
          if (abort) begin
            st <= IDLE;
            tr <= idle_tr;
          end else if (tick && tr == 5'd1) begin
            st <= DONE;
            tr <= '0;
            al <= 1'b1;
          end else begin
            if (tick) tr <= tr - 5'd1;
            if (bus.pulso_pausa) st <= PAUSE;
          end
        PAUSE:
          if (abort) begin
            st <= IDLE;
            tr <= idle_tr;
          end else if (bus.pulso_inicio) st <= RUN;
        DONE: begin
          if (tick) bl <= ~bl;
          if (abort || bus.pulso_inicio || (tick && dcnt == DMAX)) begin
            st <= IDLE;
            tr <= idle_tr;
            bl <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  assign bus.estado      = st;
  assign bus.tiempo_rest = tr;
  assign bus.fin         = (st == DONE);
  assign bus.alarma      = al;
  assign bus.parpadeo    = bl;
endmodule
